// File: rtl/cam_pkg.sv
// Shared constants and state encodings for the OV7670 configuration sequencer
// and its SCCB write engine.
package cam_pkg;

  localparam logic [15:0] END_MARK     = 16'hFFFF;
  localparam logic [15:0] DELAY_MARK   = 16'hFFF0;
  localparam logic [7:0]  OV7670_WR_ID = 8'h42;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_WRITE,
    ST_DELAY,
    ST_DONE
  } seq_state_t;

  typedef enum logic [2:0] {
    EN_IDLE,
    EN_START,
    EN_BIT,
    EN_STOP,
    EN_GAP
  } eng_state_t;

endpackage

// File: rtl/sccb_write.sv
// SCCB 3-phase write engine: start, three 9-bit phases (9th bit released), stop,
// one-cycle ack, then a 4-quarter bus-free gap. All timing in quarter-bit ticks.
module sccb_write
  import cam_pkg::*;
#(
  parameter int QTR = 10
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_req,
  input  logic [7:0] i_byte0,
  input  logic [7:0] i_byte1,
  input  logic [7:0] i_byte2,
  output logic       o_ack,
  output logic       o_sioc,
  output logic       o_siod,
  output logic       o_siod_oe
);

  // state  | meaning
  // IDLE   | bus idle high, waiting for req
  // START  | SIOD low with SIOC high for 2q
  // BIT    | 27 bits of 4q each, quarter index in qidx
  // STOP   | SIOC low 2q, SIOC high 2q, then SIOD high + ack
  // GAP    | 4q bus-free time before the next start

  localparam int QW = (QTR > 1) ? $clog2(QTR) : 1;
  localparam logic [QW-1:0] QLOAD = QW'(QTR - 1);

  eng_state_t      state;
  logic [QW-1:0]   qcnt;
  logic [1:0]      qidx;
  logic [3:0]      bidx;
  logic [1:0]      pidx;
  logic [2:0][7:0] bytes_q;
  logic            tick;

  assign tick = (qcnt == '0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= EN_IDLE;
      qcnt      <= '0;
      qidx      <= '0;
      bidx      <= '0;
      pidx      <= '0;
      bytes_q   <= '0;
      o_ack     <= 1'b0;
      o_sioc    <= 1'b1;
      o_siod    <= 1'b1;
      o_siod_oe <= 1'b1;
    end else begin
      o_ack <= 1'b0;
      if (state != EN_IDLE) begin
        qcnt <= tick ? QLOAD : qcnt - 1'b1;
        if (tick) qidx <= qidx + 1'b1;
      end
      case (state)
        EN_IDLE: begin
          if (i_req) begin
            bytes_q <= {i_byte2, i_byte1, i_byte0};
            o_siod  <= 1'b0;
            qcnt    <= QLOAD;
            qidx    <= '0;
            state   <= EN_START;
          end
        end
        EN_START: begin
          if (tick && qidx == 2'd1) begin
            state  <= EN_BIT;
            qidx   <= '0;
            bidx   <= '0;
            pidx   <= '0;
            o_sioc <= 1'b0;
            o_siod <= bytes_q[0][7];
          end
        end
        EN_BIT: begin
          if (tick) begin
            if (qidx == 2'd1) begin
              o_sioc <= 1'b1;
            end else if (qidx == 2'd3) begin
              o_sioc <= 1'b0;
              if (bidx == 4'd8) begin
                o_siod_oe <= 1'b1;
                bidx      <= '0;
                if (pidx == 2'd2) begin
                  state  <= EN_STOP;
                  o_siod <= 1'b0;
                end else begin
                  pidx   <= pidx + 2'd1;
                  o_siod <= bytes_q[pidx + 2'd1][7];
                end
              end else if (bidx == 4'd7) begin
                // 9th bit: release the line, slave level is not inspected
                bidx      <= 4'd8;
                o_siod_oe <= 1'b0;
                o_siod    <= 1'b1;
              end else begin
                bidx   <= bidx + 4'd1;
                o_siod <= bytes_q[pidx][3'd6 - bidx[2:0]];
              end
            end
          end
        end
        EN_STOP: begin
          if (tick) begin
            if (qidx == 2'd1) begin
              o_sioc <= 1'b1;
            end else if (qidx == 2'd3) begin
              o_siod <= 1'b1;
              o_ack  <= 1'b1;
              qidx   <= '0;
              state  <= EN_GAP;
            end
          end
        end
        EN_GAP: begin
          if (tick && qidx == 2'd3) state <= EN_IDLE;
        end
        default: state <= EN_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/cam_init.sv
// OV7670 register-configuration sequencer: walks a {reg_addr, reg_data} ROM,
// issues one SCCB write per entry, honours delay markers, flags completion.
module cam_init
  import cam_pkg::*;
#(
  parameter int         CLK_HZ   = 25_000_000,
  parameter int         SCCB_HZ  = 100_000,
  parameter int         DELAY_MS = 10,
  parameter logic [7:0] CAM_ID   = OV7670_WR_ID,
  parameter int         ROM_AW   = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  output logic [ROM_AW-1:0] o_rom_addr,
  input  logic [15:0]       i_rom_data,
  output logic              o_sioc,
  output logic              o_siod,
  output logic              o_siod_oe,
  output logic              o_busy,
  output logic              o_done
);

  // state  | meaning
  // IDLE   | waiting for i_start
  // FETCH  | ROM address presented, data arrives next cycle
  // DECODE | classify entry: end marker, delay marker or register write
  // WRITE  | req held to the SCCB engine until ack
  // DELAY  | wait DLY cycles
  // DONE   | terminal, left only through reset

  localparam int QTR = CLK_HZ / (4 * SCCB_HZ);
  localparam int DLY = DELAY_MS * (CLK_HZ / 1000);
  localparam int DW  = $clog2(DLY + 1);

  seq_state_t     state;
  logic [15:0]    entry;
  logic           req;
  logic           ack;
  logic [DW-1:0]  dcnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= ST_IDLE;
      o_rom_addr <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      entry      <= '0;
      req        <= 1'b0;
      dcnt       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            o_busy <= 1'b1;
            state  <= ST_FETCH;
          end
        end
        ST_FETCH: state <= ST_DECODE;
        ST_DECODE: begin
          entry <= i_rom_data;
          if (i_rom_data == END_MARK) begin
            state <= ST_DONE;
          end else if (i_rom_data == DELAY_MARK) begin
            dcnt  <= DW'(DLY - 1);
            state <= ST_DELAY;
          end else begin
            req   <= 1'b1;
            state <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (ack) begin
            req <= 1'b0;
            // the last ROM slot ends the sequence rather than wrapping to 0
            if (&o_rom_addr) begin
              state <= ST_DONE;
            end else begin
              o_rom_addr <= o_rom_addr + 1'b1;
              state      <= ST_FETCH;
            end
          end
        end
        ST_DELAY: begin
          if (dcnt == '0) begin
            if (&o_rom_addr) begin
              state <= ST_DONE;
            end else begin
              o_rom_addr <= o_rom_addr + 1'b1;
              state      <= ST_FETCH;
            end
          end else begin
            dcnt <= dcnt - 1'b1;
          end
        end
        ST_DONE: begin
          o_done <= 1'b1;
          o_busy <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  sccb_write #(
    .QTR(QTR)
  ) u_sccb (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_req     (req),
    .i_byte0   (CAM_ID),
    .i_byte1   (entry[15:8]),
    .i_byte2   (entry[7:0]),
    .o_ack     (ack),
    .o_sioc    (o_sioc),
    .o_siod    (o_siod),
    .o_siod_oe (o_siod_oe)
  );

endmodule

// File: tb/tb_cam_init.sv
// Directed bench for cam_init: SCCB slave/bus monitor plus per-scenario tasks
// with hand-computed byte logs and cycle timings (QTR=10, DLY=4000, ROM_AW=2).
module tb_cam_init;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  rom_addr;
  logic [15:0] rom_data = '0;
  logic        sioc, siod, oe, busy, done;
  logic [15:0] rom [4];
  logic        slave_bit = 1'b1;
  wire         bus = oe ? siod : slave_bit;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= rom[rom_addr];

  cam_init #(
    .CLK_HZ(4_000_000), .SCCB_HZ(100_000), .DELAY_MS(1), .CAM_ID(8'h42), .ROM_AW(2)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .o_rom_addr(rom_addr),
    .i_rom_data(rom_data), .o_sioc(sioc), .o_siod(siod), .o_siod_oe(oe),
    .o_busy(busy), .o_done(done)
  );

  // bus monitor, sampled on the falling edge
  localparam int BIG = 1_000_000_000;
  logic       mon_clr = 1'b0;
  logic       p_sioc = 1'b1, p_siod = 1'b1, p_done = 1'b0, p_busy = 1'b0;
  logic       in_frame = 1'b0;
  logic [7:0] sh = '0;
  logic [7:0] log_q [$];
  int         start_q [$];
  int         stop_q [$];
  int cyc = 0, rises = 0, last_rise = -1, toggles = 0, viol = 0;
  int hold_min = BIG, hold_max = -1, per_min = BIG, per_max = -1;
  int sgap_min = BIG, sgap_max = -1, oe_min = BIG, oe_max = -1, oe_len = 0, oe_runs = 0;
  int done_cyc = -1;
  logic busy_at_done = 1'b0, busy_before_done = 1'b0;

  always @(negedge clk) begin
    if (mon_clr) begin
      log_q.delete(); start_q.delete(); stop_q.delete();
      in_frame = 1'b0; rises = 0; last_rise = -1; sh = '0; toggles = 0; viol = 0;
      hold_min = BIG; hold_max = -1; per_min = BIG; per_max = -1;
      sgap_min = BIG; sgap_max = -1; oe_min = BIG; oe_max = -1; oe_len = 0; oe_runs = 0;
      done_cyc = -1; busy_at_done = 1'b0; busy_before_done = 1'b0;
    end else begin
      if (sioc != p_sioc) toggles++;
      if (p_sioc && sioc && p_siod && !siod && !in_frame) begin
        in_frame = 1'b1; rises = 0; last_rise = -1; start_q.push_back(cyc);
      end else if (p_sioc && sioc && !p_siod && siod && in_frame) begin
        in_frame = 1'b0; stop_q.push_back(cyc);
        if (cyc - last_rise < sgap_min) sgap_min = cyc - last_rise;
        if (cyc - last_rise > sgap_max) sgap_max = cyc - last_rise;
        if (rises != 28) viol++;
      end else if (p_sioc && sioc && siod != p_siod) begin
        viol++;
      end
      if (in_frame && p_sioc && !sioc && rises == 0) begin
        if (cyc - start_q[$] < hold_min) hold_min = cyc - start_q[$];
        if (cyc - start_q[$] > hold_max) hold_max = cyc - start_q[$];
      end
      if (in_frame && !p_sioc && sioc) begin
        if (last_rise >= 0) begin
          if (cyc - last_rise < per_min) per_min = cyc - last_rise;
          if (cyc - last_rise > per_max) per_max = cyc - last_rise;
        end
        last_rise = cyc;
        if (rises < 27 && (rises % 9) < 8) begin
          sh = {sh[6:0], bus};
          if ((rises % 9) == 7) log_q.push_back(sh);
        end
        rises++;
      end
      if (!oe) oe_len++;
      else if (oe_len > 0) begin
        if (oe_len < oe_min) oe_min = oe_len;
        if (oe_len > oe_max) oe_max = oe_len;
        oe_runs++; oe_len = 0;
      end
      if (done && !p_done) begin
        done_cyc = cyc; busy_at_done = busy; busy_before_done = p_busy;
      end
    end
    p_sioc = sioc; p_siod = siod; p_done = done; p_busy = busy;
    cyc++;
  end

  task automatic clear_mon();
    mon_clr = 1'b1;
    @(negedge clk);
    #1 mon_clr = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 rst = 1'b1; start = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    clear_mon();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int limit);
    int n = 0;
    while (done !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_done_timeout: done=%b want 1 within %0d cycles", tag, done, limit);
    end
    @(negedge clk);
    #1;
  endtask

  // ROM {1280, FFF0, 1204, FFFF}: two writes separated by a 4000-cycle delay
  task automatic run_cfg_seq(input string tag, input logic lvl, output int dur);
    logic [7:0] exp [6];
    exp = '{8'h42, 8'h12, 8'h80, 8'h42, 8'h12, 8'h04};
    dur = -1;
    slave_bit = lvl;
    pulse_start();
    wait_done(tag, 20000);
    vectors++;
    if (log_q.size() != 6) begin
      miscompares++;
      $display("FAIL %s_byte_count: got %0d want 6", tag, log_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        vectors++;
        if (log_q[i] !== exp[i]) begin
          miscompares++;
          $display("FAIL %s_byte%0d: got %h want %h", tag, i, log_q[i], exp[i]);
        end
      end
    end
    vectors++;
    if (start_q.size() != 2 || stop_q.size() != 2) begin
      miscompares++;
      $display("FAIL %s_frames: got %0d starts %0d stops want 2 2", tag, start_q.size(), stop_q.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (stop_q[i] - start_q[i] != 1140) begin
          miscompares++;
          $display("FAIL %s_frame%0d_len: got %0d want 1140", tag, i, stop_q[i] - start_q[i]);
        end
      end
      vectors++;
      if (start_q[1] - stop_q[0] < 4000) begin
        miscompares++;
        $display("FAIL %s_delay_gap: got %0d want >=4000", tag, start_q[1] - stop_q[0]);
      end
      vectors++;
      if (start_q[1] - start_q[0] != 5146) begin
        miscompares++;
        $display("FAIL %s_start_spacing: got %0d want 5146", tag, start_q[1] - start_q[0]);
      end
      vectors++;
      if (done_cyc - stop_q[1] != 4) begin
        miscompares++;
        $display("FAIL %s_done_after_ack: got %0d want 4", tag, done_cyc - stop_q[1]);
      end
      dur = done_cyc - start_q[0];
      vectors++;
      if (dur != 6290) begin
        miscompares++;
        $display("FAIL %s_duration: got %0d want 6290", tag, dur);
      end
    end
    vectors++;
    if ({busy_before_done, busy_at_done} !== 2'b10) begin
      miscompares++;
      $display("FAIL %s_busy_edge: got before/at=%b%b want 10", tag, busy_before_done, busy_at_done);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    vectors++;
    if ({sioc, siod, oe, rom_addr, busy, done} !== 7'b1110000) begin
      miscompares++;
      $display("FAIL reset_state: got %b want 1110000", {sioc, siod, oe, rom_addr, busy, done});
    end
    do_reset();
    repeat (5) @(negedge clk);
    #1;
    vectors++;
    if ({sioc, siod, oe, rom_addr, busy, done} !== 7'b1110000) begin
      miscompares++;
      $display("FAIL idle_state: got %b want 1110000", {sioc, siod, oe, rom_addr, busy, done});
    end
  endtask

  task automatic test_sequence();
    int dur;
    rom = '{16'h1280, 16'hFFF0, 16'h1204, 16'hFFFF};
    do_reset();
    run_cfg_seq("seq", 1'b1, dur);
  endtask

  task automatic test_timing();
    vectors++;
    if (hold_min != 20 || hold_max != 20) begin
      miscompares++;
      $display("FAIL start_hold: got %0d..%0d want 20", hold_min, hold_max);
    end
    vectors++;
    if (per_min != 40 || per_max != 40) begin
      miscompares++;
      $display("FAIL sioc_period: got %0d..%0d want 40", per_min, per_max);
    end
    vectors++;
    if (sgap_min != 20 || sgap_max != 20) begin
      miscompares++;
      $display("FAIL stop_siod_delay: got %0d..%0d want 20", sgap_min, sgap_max);
    end
    vectors++;
    if (viol != 0) begin
      miscompares++;
      $display("FAIL siod_stability: got %0d violations want 0", viol);
    end
    vectors++;
    if (oe_runs != 6 || oe_min != 40 || oe_max != 40) begin
      miscompares++;
      $display("FAIL ninth_bit_release: got %0d runs %0d..%0d want 6 runs of 40", oe_runs, oe_min, oe_max);
    end
  endtask

  task automatic test_ninth_bit();
    int dur0, dur1;
    rom = '{16'h1280, 16'hFFF0, 16'h1204, 16'hFFFF};
    do_reset();
    run_cfg_seq("slave0", 1'b0, dur0);
    do_reset();
    run_cfg_seq("slave1", 1'b1, dur1);
    vectors++;
    if (dur0 != dur1) begin
      miscompares++;
      $display("FAIL slave_level_timing: got %0d vs %0d want equal", dur0, dur1);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    int dur;
    rom = '{16'h1280, 16'hFFF0, 16'h1204, 16'hFFFF};
    do_reset();
    slave_bit = 1'b1;
    pulse_start();
    while (rises < 21 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (rises < 21) begin
      miscompares++;
      $display("FAIL mid_reset_reach: got %0d rises want >=21", rises);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({sioc, siod, oe, rom_addr, busy, done} !== 7'b1110000) begin
      miscompares++;
      $display("FAIL mid_reset_state: got %b want 1110000", {sioc, siod, oe, rom_addr, busy, done});
    end
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    clear_mon();
    run_cfg_seq("replay", 1'b1, dur);
  endtask

  task automatic test_end_marker();
    rom = '{16'hFFFF, 16'h1280, 16'h1204, 16'h3344};
    do_reset();
    pulse_start();
    @(negedge clk);
    @(negedge clk);
    #1;
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL end_mark_early: done=%b want 0 two cycles after start", done);
    end
    @(negedge clk);
    #1;
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL end_mark_done: done/busy=%b%b want 10 three cycles after start", done, busy);
    end
    repeat (100) @(negedge clk);
    #1;
    vectors++;
    if (toggles != 0 || rom_addr !== 2'd0) begin
      miscompares++;
      $display("FAIL end_mark_bus: got %0d toggles addr %0d want 0 0", toggles, rom_addr);
    end
  endtask

  task automatic test_no_end_marker();
    int n = 0;
    logic [7:0] exp [12];
    rom = '{16'h0A11, 16'h1B22, 16'h2C33, 16'h3D44};
    for (int i = 0; i < 4; i++) begin
      exp[3*i] = 8'h42; exp[3*i+1] = rom[i][15:8]; exp[3*i+2] = rom[i][7:0];
    end
    do_reset();
    slave_bit = 1'b0;
    pulse_start();
    while (stop_q.size() < 1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    start = 1'b1;
    repeat (5) @(negedge clk);
    #1 start = 1'b0;
    wait_done("no_end", 10000);
    vectors++;
    if (log_q.size() != 12) begin
      miscompares++;
      $display("FAIL no_end_byte_count: got %0d want 12", log_q.size());
    end else begin
      for (int i = 0; i < 12; i++) begin
        vectors++;
        if (log_q[i] !== exp[i]) begin
          miscompares++;
          $display("FAIL no_end_byte%0d: got %h want %h", i, log_q[i], exp[i]);
        end
      end
    end
    vectors++;
    if (start_q.size() != 4 || stop_q.size() != 4) begin
      miscompares++;
      $display("FAIL no_end_frames: got %0d starts %0d stops want 4 4", start_q.size(), stop_q.size());
    end else begin
      vectors++;
      if (start_q[1] - stop_q[0] != 41) begin
        miscompares++;
        $display("FAIL bus_free_gap: got %0d want 41", start_q[1] - stop_q[0]);
      end
      vectors++;
      if (done_cyc - stop_q[3] != 2) begin
        miscompares++;
        $display("FAIL last_slot_done: got %0d want 2", done_cyc - stop_q[3]);
      end
    end
    vectors++;
    if (rom_addr !== 2'd3 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL no_wrap: addr/busy=%0d/%b want 3/0", rom_addr, busy);
    end
    pulse_start();
    repeat (300) @(negedge clk);
    #1;
    vectors++;
    if (start_q.size() != 4 || done !== 1'b1 || busy !== 1'b0 || rom_addr !== 2'd3) begin
      miscompares++;
      $display("FAIL done_sticky: starts=%0d done=%b busy=%b addr=%0d want 4 1 0 3",
               start_q.size(), done, busy, rom_addr);
    end
  endtask

  initial begin
    rom = '{16'h1280, 16'hFFF0, 16'h1204, 16'hFFFF};
    test_reset();
    test_sequence();
    test_timing();
    test_ninth_bit();
    test_reset_mid();
    test_end_marker();
    test_no_end_marker();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
